// File: rtl/rr_arb_ffo.sv
// rr_arb_ffo: round-robin arbiter with a two-pass first-one search (above last winner, then all).
// Optional macro RR_ARB_FFO_LOCK_EN holds the selected requester across downstream stalls.
module rr_arb_ffo #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [NumIn-1:0]                    req_i,
    output logic [NumIn-1:0]                    gnt_o,
    input  logic [NumIn-1:0][DataWidth-1:0]     data_i,
    output logic                                req_o,
    input  logic                                gnt_i,
    output logic [DataWidth-1:0]                data_o,
    output logic [IdxWidth-1:0]                 idx_o
);

    logic [IdxWidth-1:0] r_rr;
    logic [NumIn-1:0]    w_req_masked;
    logic [IdxWidth-1:0] w_idx_m;
    logic [IdxWidth-1:0] w_idx_u;
    logic                w_any_m;
    logic [IdxWidth-1:0] w_idx_rr;
    logic                w_locked;
    logic [IdxWidth-1:0] w_lock_idx;
    logic                w_hs;
    logic                w_stall;

    // Pass 1 only sees requesters strictly above the last winner; rr at NumIn-1 empties the mask.
    always_comb begin
        w_req_masked = '0;
        for (int i = 0; i < NumIn; i++) begin
            w_req_masked[i] = req_i[i] && (IdxWidth'(i) > r_rr);
        end
    end

    always_comb begin
        w_idx_m = '0;
        w_idx_u = '0;
        w_any_m = 1'b0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            if (w_req_masked[i]) begin
                w_idx_m = IdxWidth'(i);
                w_any_m = 1'b1;
            end
            if (req_i[i]) begin
                w_idx_u = IdxWidth'(i);
            end
        end
    end

    assign w_idx_rr = w_any_m ? w_idx_m : w_idx_u;
    assign idx_o    = w_locked ? w_lock_idx : w_idx_rr;
    assign req_o    = w_locked | (|req_i);
    assign data_o   = data_i[idx_o];
    assign w_hs     = req_o & gnt_i;
    assign w_stall  = req_o & ~gnt_i;

    always_comb begin
        gnt_o = '0;
        if (w_hs) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rr <= '0;
        end else if (w_hs) begin
            r_rr <= idx_o;
        end
    end

`ifdef RR_ARB_FFO_LOCK_EN
    // state      | meaning
    // ST_IDLE    | selection re-evaluated every cycle
    // ST_LOCKED  | stalled winner held in r_lock_idx until its handshake
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_st;
    logic [IdxWidth-1:0] r_lock_idx;

    assign w_locked   = (r_st == ST_LOCKED);
    assign w_lock_idx = r_lock_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_st       <= ST_IDLE;
            r_lock_idx <= '0;
        end else if (w_hs) begin
            r_st <= ST_IDLE;
        end else if (w_stall && (r_st == ST_IDLE)) begin
            r_st       <= ST_LOCKED;
            r_lock_idx <= w_idx_rr;
        end
    end
`else
    assign w_locked   = 1'b0;
    assign w_lock_idx = '0;
`endif

endmodule

// File: tb/tb_rr_arb_ffo.sv
// Directed-vector bench for rr_arb_ffo: a 4-input and a 3-input instance.
// Expectations switch on RR_ARB_FFO_LOCK_EN to match the build under test.
module tb_rr_arb_ffo;

    localparam logic [31:0] DBASE = 32'hA5A5_0000;

`ifdef RR_ARB_FFO_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;

    logic [3:0]       req4 = '0;
    logic [3:0]       gnt4_o;
    logic [3:0][31:0] data4;
    logic             req4_o;
    logic             gnt4 = 1'b0;
    logic [31:0]      data4_o;
    logic [1:0]       idx4_o;

    logic [2:0]       req3 = '0;
    logic [2:0]       gnt3_o;
    logic [2:0][31:0] data3;
    logic             req3_o;
    logic             gnt3 = 1'b0;
    logic [31:0]      data3_o;
    logic [1:0]       idx3_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_i = ~clk_i;

    initial begin
        for (int i = 0; i < 4; i++) data4[i] = DBASE + 32'(i);
        for (int i = 0; i < 3; i++) data3[i] = DBASE + 32'h100 + 32'(i);
    end

    rr_arb_ffo #(.NumIn(4), .DataWidth(32)) u_dut4 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .req_i   (req4),
        .gnt_o   (gnt4_o),
        .data_i  (data4),
        .req_o   (req4_o),
        .gnt_i   (gnt4),
        .data_o  (data4_o),
        .idx_o   (idx4_o)
    );

    rr_arb_ffo #(.NumIn(3), .DataWidth(32)) u_dut3 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .req_i   (req3),
        .gnt_o   (gnt3_o),
        .data_i  (data3),
        .req_o   (req3_o),
        .gnt_i   (gnt3),
        .data_o  (data3_o),
        .idx_o   (idx3_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk4(input string tag, input int e_idx, input logic e_req, input logic [3:0] e_gnt);
        #1;
        check({tag, "_idx"},  32'(idx4_o), 32'(e_idx));
        check({tag, "_req"},  32'(req4_o), 32'(e_req));
        check({tag, "_gnt"},  32'(gnt4_o), 32'(e_gnt));
        check({tag, "_data"}, data4_o,     DBASE + 32'(e_idx));
    endtask

    task automatic drive4(input logic [3:0] r, input logic g);
        req4 = r;
        gnt4 = g;
    endtask

    initial begin
        int rot [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        int seq5 [3] = '{0, 2, 0};
        int rot3 [6] = '{1, 2, 0, 1, 2, 0};

        tick();
        tick();
        rst_i = 1'b0;
        chk4("reset", 0, 1'b0, 4'b0000);

        drive4(4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk4($sformatf("rot%0d", k), rot[k], 1'b1, 4'(1 << rot[k]));
            tick();
        end

        drive4(4'b1000, 1'b1);
        chk4("to3", 3, 1'b1, 4'b1000);
        tick();
        drive4(4'b0101, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk4($sformatf("wrap%0d", k), seq5[k], 1'b1, 4'(1 << seq5[k]));
            tick();
        end

        drive4(4'b0000, 1'b1);
        chk4("noreq_g1", 0, 1'b0, 4'b0000);
        tick();
        drive4(4'b0000, 1'b0);
        chk4("noreq_g0", 0, 1'b0, 4'b0000);
        tick();
        drive4(4'b1111, 1'b1);
        chk4("rr_kept", 1, 1'b1, 4'b0010);
        tick();

        drive4(4'b1000, 1'b1);
        tick();
        drive4(4'b0100, 1'b0);
        chk4("stall0", 2, 1'b1, 4'b0000);
        tick();
        drive4(4'b0111, 1'b0);
        chk4("stall1", LOCK ? 2 : 0, 1'b1, 4'b0000);
        tick();
        drive4(4'b0111, 1'b1);
        chk4("release", LOCK ? 2 : 0, 1'b1, LOCK ? 4'b0100 : 4'b0001);
        tick();
        chk4("after_rel", LOCK ? 0 : 1, 1'b1, LOCK ? 4'b0001 : 4'b0010);
        tick();

        drive4(4'b1000, 1'b1);
        tick();
        drive4(4'b0100, 1'b0);
        tick();
        drive4(4'b0011, 1'b0);
        flush_i = 1'b1;
        chk4("pre_flush", LOCK ? 2 : 0, 1'b1, 4'b0000);
        tick();
        flush_i = 1'b0;
        chk4("post_flush", 1, 1'b1, 4'b0000);

        drive4(4'b1000, 1'b1);
        tick();
        drive4(4'b0100, 1'b0);
        tick();
        drive4(4'b0011, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk4("post_rst", 1, 1'b1, 4'b0000);

        drive4(4'b1000, 1'b1);
        tick();
        flush_i = 1'b1;
        chk4("hs_flush", 3, 1'b1, 4'b1000);
        tick();
        flush_i = 1'b0;
        drive4(4'b1111, 1'b1);
        chk4("flush_won", 1, 1'b1, 4'b0010);
        tick();
        drive4(4'b0000, 1'b0);

        req3 = 3'b111;
        gnt3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("n3_idx%0d", k),  32'(idx3_o), 32'(rot3[k]));
            check($sformatf("n3_gnt%0d", k),  32'(gnt3_o), 32'(1 << rot3[k]));
            check($sformatf("n3_data%0d", k), data3_o,     DBASE + 32'h100 + 32'(rot3[k]));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
